// File: rtl/ps2_pkg.sv
// Shared constants and types for the AXI-Lite PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_PARITY    = 3;
  localparam int STAT_FRAME     = 4;
  localparam int STAT_COUNT_LSB = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, clock glitch filter,
// frame FSM and mid-frame timeout. Emits single-cycle byte/error pulses.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          fall;

  ps2_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // The filtered clock drops on the FILTER_LEN-th consecutive low sample.
  assign fall = filt_q && !clk_sync_q[1] && (filt_cnt_q == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_d        = '0;
    byte_valid_o = 1'b0;
    parity_err_o = 1'b0;
    frame_err_o  = 1'b0;

    if (state_q != IDLE) tmo_d = fall ? '0 : tmo_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (fall && !data_sync_q[1]) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {data_sync_q[1], shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = data_sync_q[1];
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (!(^{shift_q, parity_q})) parity_err_o = 1'b1;
          else if (!data_sync_q[1])    frame_err_o  = 1'b1;
          else                         byte_valid_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled device abandons the frame after TIMEOUT_CYCLES quiet cycles.
    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = IDLE;
      frame_err_o = 1'b1;
      tmo_d       = '0;
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/axil_ps2.sv
// AXI4-Lite PS/2 keyboard peripheral: scan-code FIFO, DATA/STATUS/CTRL
// registers and a level interrupt on top of the ps2_rx frame receiver.
module axil_ps2
  import ps2_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic                  ps2_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic          rx_valid, rx_perr, rx_ferr;
  logic [7:0]    rx_byte;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d, perr_q, perr_d, ferr_q, ferr_d;
  logic          irq_en_q, irq_en_d, irq_q;
  logic          rvalid_q, bvalid_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q, bresp_q;

  logic          not_empty, full, ar_hs, aw_hs, pop, push, wr_strobe;
  logic [1:0]    rd_sel, wr_sel;
  logic [31:0]   rd_word;
  logic [1:0]    rd_resp;
  logic [4:2]    clr;
  logic          unused_bits;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i       (clk),
    .rst_i       (rst),
    .ps2_clk_i   (ps2_clk),
    .ps2_data_i  (ps2_data),
    .byte_valid_o(rx_valid),
    .byte_o      (rx_byte),
    .parity_err_o(rx_perr),
    .frame_err_o (rx_ferr)
  );

  assign not_empty = count_q != '0;
  assign full      = count_q == CW'(FIFO_DEPTH);
  assign rd_sel    = s_axil_araddr[3:2];
  assign wr_sel    = s_axil_awaddr[3:2];
  assign ar_hs     = s_axil_arvalid && !rvalid_q;
  assign aw_hs     = s_axil_awvalid && s_axil_wvalid && !bvalid_q;
  assign wr_strobe = aw_hs && s_axil_wstrb[0];
  assign pop       = ar_hs && (rd_sel == REG_DATA) && not_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push      = rx_valid && (!full || pop);

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      REG_DATA:   if (not_empty) rd_word = {23'd0, 1'b1, fifo_q[rd_ptr_q]};
      REG_STATUS: begin
        rd_word[STAT_COUNT_LSB +: 8] = 8'(count_q);
        rd_word[STAT_FRAME]          = ferr_q;
        rd_word[STAT_PARITY]         = perr_q;
        rd_word[STAT_OVERRUN]        = overrun_q;
        rd_word[STAT_FULL]           = full;
        rd_word[STAT_NOT_EMPTY]      = not_empty;
      end
      REG_CTRL:   rd_word[0] = irq_en_q;
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    count_d   = count_q + CW'(push) - CW'(pop);
    clr       = (wr_strobe && wr_sel == REG_STATUS) ? s_axil_wdata[4:2] : 3'b000;
    overrun_d = (overrun_q && !clr[STAT_OVERRUN]) || (rx_valid && full && !pop);
    perr_d    = (perr_q && !clr[STAT_PARITY]) || rx_perr;
    ferr_d    = (ferr_q && !clr[STAT_FRAME]) || rx_ferr;
    irq_en_d  = (wr_strobe && wr_sel == REG_CTRL) ? s_axil_wdata[0] : irq_en_q;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_en_q && not_empty;

      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= rd_resp;
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end

      if (aw_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_sel == 2'd3) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign s_axil_arready = !rvalid_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_awready = aw_hs;
  assign s_axil_wready  = aw_hs;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign ps2_irq        = irq_q;

  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_wdata, s_axil_wstrb,
                         s_axil_awaddr, s_axil_araddr};

endmodule

// File: tb/tb_axil_ps2.sv
// Bench for axil_ps2: a directed frame table, multi-cycle corner sequences
// and a randomized run checked against a queue-based model of the register map.
module tb_axil_ps2;

  localparam int HALF  = 20;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        ps2Clk, ps2Data, irq;

  int total = 0;
  int bad   = 0;
  event stopFall;

  logic [7:0] modelQ[$];
  bit modelOvr, modelPar, modelFrm;

  typedef struct {
    logic [7:0]  data;
    bit          parOk;
    bit          stopOk;
    logic [31:0] expStatus;
    logic [31:0] expData;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  axil_ps2 #(.ADDR_WIDTH(8), .FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYCLES(5000)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .ps2_clk(ps2Clk), .ps2_data(ps2Data), .ps2_irq(irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ps2Bit(input logic b, input bit isStop);
    ps2Data = b;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    if (isStop) -> stopFall;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  // Sends one full 11-bit frame; odd parity unless parOk is clear.
  task automatic applyStimulus(input logic [7:0] data, input bit parOk, input bit stopOk);
    logic par;
    par = parOk ? ~^data : ^data;
    ps2Bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(data[i], 1'b0);
    ps2Bit(par, 1'b0);
    ps2Bit(stopOk, 1'b1);
    ps2Data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic axiRead(input logic [7:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    araddr  = addr;
    arvalid = 1'b1;
    rready  = (hold == 0);
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      rready = 1'b1;
    end
    checkOutput("readRvalid", 32'(rvalid), 32'd1);
    data = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  task automatic axiWrite(input logic [7:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    awaddr  = addr;
    wdata   = data;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    while (!awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    checkOutput("writeBvalid", 32'(bvalid), 32'd1);
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic modelFrame(input logic [7:0] d, input bit parOk, input bit stopOk);
    if (!parOk)                        modelPar = 1'b1;
    else if (!stopOk)                  modelFrm = 1'b1;
    else if (modelQ.size() == DEPTH)   modelOvr = 1'b1;
    else                               modelQ.push_back(d);
  endtask

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s        = 32'd0;
    s[15:8]  = 8'(modelQ.size());
    s[4]     = modelFrm;
    s[3]     = modelPar;
    s[2]     = modelOvr;
    s[1]     = (modelQ.size() == DEPTH);
    s[0]     = (modelQ.size() != 0);
    return s;
  endfunction

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [31:0] d, exp;
    logic [1:0]  r;
    logic [7:0]  rb;
    bit          pOk, sOk;
    int          nr, m;

    vecs[0] = '{8'h1C, 1'b1, 1'b1, 32'h0000_0101, 32'h0000_011C};
    vecs[1] = '{8'h1C, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000};
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 32'h0000_0101, 32'h0000_01FF};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 32'h0000_0101, 32'h0000_0100};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_0000};

    rst = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1; bready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstRvalid", 32'(rvalid), 32'd0);
    checkOutput("rstBvalid", 32'(bvalid), 32'd0);
    checkOutput("rstIrq", 32'(irq), 32'd0);
    checkOutput("rstArready", 32'(arready), 32'd1);
    checkOutput("rstRdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    axiRead(8'h04, 0, d, r);
    checkOutput("rstStatus", d, 32'd0);
    axiRead(8'h08, 0, d, r);
    checkOutput("rstCtrl", d, 32'd0);

    axiWrite(8'h08, 32'd1, r);
    checkOutput("ctrlBresp", 32'(r), 32'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].parOk, vecs[i].stopOk);
      axiRead(8'h04, 0, d, r);
      checkOutput("vecStatus", d, vecs[i].expStatus);
      checkOutput("vecIrq", 32'(irq), 32'(vecs[i].expStatus[0]));
      axiRead(8'h00, 0, d, r);
      checkOutput("vecData", d, vecs[i].expData);
      checkOutput("vecIrqAfterPop", 32'(irq), 32'd0);
      axiWrite(8'h04, 32'h1C, r);
      axiRead(8'h04, 0, d, r);
      checkOutput("vecCleared", d, 32'd0);
    end

    for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 1'b1, 1'b1);
    axiRead(8'h04, 0, d, r);
    checkOutput("ovrStatus", d, 32'h0000_0807);
    checkOutput("ovrIrq", 32'(irq), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      axiRead(8'h00, 0, d, r);
      checkOutput("ovrData", d, 32'h100 + 32'(i));
    end
    axiRead(8'h00, 0, d, r);
    checkOutput("ovrEmptyRead", d, 32'd0);
    axiRead(8'h04, 0, d, r);
    checkOutput("ovrSticky", d, 32'h0000_0004);
    axiWrite(8'h04, 32'h04, r);

    ps2Bit(1'b0, 1'b0);
    ps2Bit(1'b1, 1'b0);
    ps2Bit(1'b0, 1'b0);
    ps2Bit(1'b1, 1'b0);
    ps2Bit(1'b1, 1'b0);
    ps2Data = 1'b1;
    repeat (6000) @(negedge clk);
    axiRead(8'h04, 0, d, r);
    checkOutput("tmoStatus", d, 32'h0000_0010);
    axiWrite(8'h04, 32'h10, r);
    applyStimulus(8'hF0, 1'b1, 1'b1);
    axiRead(8'h00, 0, d, r);
    checkOutput("tmoNextFrame", d, 32'h0000_01F0);
    axiRead(8'h04, 0, d, r);
    checkOutput("tmoStatusAfter", d, 32'd0);

    applyStimulus(8'h31, 1'b1, 1'b1);
    applyStimulus(8'h32, 1'b1, 1'b1);
    applyStimulus(8'h33, 1'b1, 1'b1);
    axiRead(8'h04, 0, d, r);
    checkOutput("ppStatusBefore", d, 32'h0000_0301);
    fork
      applyStimulus(8'h34, 1'b1, 1'b1);
      begin
        @(stopFall);
        repeat (5) @(negedge clk);
        axiRead(8'h00, 5, d, r);
      end
    join
    checkOutput("ppFirst", d, 32'h0000_0131);
    axiRead(8'h04, 0, d, r);
    checkOutput("ppStatusAfter", d, 32'h0000_0301);
    for (int i = 2; i <= 4; i++) begin
      axiRead(8'h00, 0, d, r);
      checkOutput("ppOrder", d, 32'h130 + 32'(i));
    end

    axiRead(8'h0C, 0, d, r);
    checkOutput("unmapRdata", d, 32'd0);
    checkOutput("unmapRresp", 32'(r), 32'd2);
    axiWrite(8'h0C, 32'hFFFF_FFFF, r);
    checkOutput("unmapBresp", 32'(r), 32'd2);
    axiRead(8'h08, 0, d, r);
    checkOutput("unmapNoEffect", d, 32'd1);

    modelQ.delete();
    modelOvr = 1'b0; modelPar = 1'b0; modelFrm = 1'b0;
    for (int it = 0; it < 24; it++) begin
      rb  = 8'($urandom);
      pOk = ($urandom_range(0, 5) != 0);
      sOk = ($urandom_range(0, 5) != 0);
      modelFrame(rb, pOk, sOk);
      applyStimulus(rb, pOk, sOk);
      nr = $urandom_range(0, 2);
      for (int k = 0; k < nr; k++) begin
        axiRead(8'h00, $urandom_range(0, 2), d, r);
        exp = 32'd0;
        if (modelQ.size() != 0) exp = {23'd0, 1'b1, modelQ.pop_front()};
        checkOutput("rndData", d, exp);
      end
      if ($urandom_range(0, 3) == 0) begin
        m = $urandom_range(0, 7);
        axiWrite(8'h04, 32'(m) << 2, r);
        if (m[0]) modelOvr = 1'b0;
        if (m[1]) modelPar = 1'b0;
        if (m[2]) modelFrm = 1'b0;
      end
      axiRead(8'h04, 0, d, r);
      checkOutput("rndStatus", d, modelStatus());
      checkOutput("rndIrq", 32'(irq), 32'(modelQ.size() != 0));
    end
    while (modelQ.size() != 0) begin
      axiRead(8'h00, 0, d, r);
      exp = {23'd0, 1'b1, modelQ.pop_front()};
      checkOutput("rndDrain", d, exp);
    end
    axiWrite(8'h04, 32'h1C, r);

    applyStimulus(8'h55, 1'b1, 1'b1);
    axiRead(8'h00, 0, d, r);
    checkOutput("preRstData", d, 32'h0000_0155);
    applyStimulus(8'h66, 1'b1, 1'b1);
    checkOutput("preRstIrq", 32'(irq), 32'd1);
    ps2Bit(1'b0, 1'b0);
    ps2Bit(1'b1, 1'b0);
    ps2Bit(1'b0, 1'b0);
    ps2Data = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstRvalid", 32'(rvalid), 32'd0);
    checkOutput("midRstBvalid", 32'(bvalid), 32'd0);
    checkOutput("midRstIrq", 32'(irq), 32'd0);
    checkOutput("midRstRdata", rdata, 32'd0);
    checkOutput("midRstRresp", 32'(rresp), 32'd0);
    checkOutput("midRstArready", 32'(arready), 32'd1);
    checkOutput("midRstAwready", 32'(awready), 32'd0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    axiRead(8'h04, 0, d, r);
    checkOutput("postRstStatus", d, 32'd0);
    axiRead(8'h08, 0, d, r);
    checkOutput("postRstCtrl", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
